// File: rtl/modem_ctrl_pkg.sv
// Shared types for the modem loopback test sequencer.
// State encoding, grid-point widths and the result record layout.
package modem_ctrl_pkg;

  localparam int SS_W  = 4;
  localparam int M_W   = 3;
  localparam int RES_W = 24;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_APPLY   = 3'd1,
    S_SETTLE  = 3'd2,
    S_MEASURE = 3'd3,
    S_REPORT  = 3'd4,
    S_NEXT    = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  typedef struct packed {
    logic [SS_W-1:0]  ss;
    logic [M_W-1:0]   m;
    logic [RES_W-1:0] bits;
    logic [RES_W-1:0] errs;
    logic             nolock;
  } res_t;

endpackage

// File: rtl/ber_sweep_ctrl_sat_cnt.sv
// Saturating up-counter with synchronous clear and count enable.
// Used for the bit, error and cycle counters of the sweep sequencer.
module sat_cnt #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= '0;
    end else if (en && (q != '1)) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/ber_sweep_ctrl.sv
// BER sweep sequencer: walks the PHY over an (ss, m) grid, measures
// bits/errors per point and hands one result record per point downstream.
module ber_sweep_ctrl
  import modem_ctrl_pkg::*;
#(
  parameter int CNT_W   = 24,
  parameter int RST_CYC = 16,
  parameter int LOCK_TO = 65535
) (
  input  logic             clk_h,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [3:0]       ss_first,
  input  logic [3:0]       ss_last,
  input  logic [2:0]       m_first,
  input  logic [2:0]       m_last,
  input  logic [CNT_W-1:0] n_bits,
  input  logic             chk_val,
  input  logic             chk_err,
  input  logic             chk_lock,
  output logic [3:0]       ss_out,
  output logic [2:0]       m_out,
  output logic             phy_rst_n,
  output logic             busy,
  output logic             done,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [3:0]       res_ss,
  output logic [2:0]       res_m,
  output logic [CNT_W-1:0] res_bits,
  output logic [CNT_W-1:0] res_errs,
  output logic             res_nolock
);

  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYC - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(LOCK_TO - 1);

  state_t st, nxt;

  logic [SS_W-1:0]  ss_lo, ss_hi, adv_ss;
  logic [M_W-1:0]   m_lo, m_hi, adv_m;
  logic [CNT_W-1:0] nb, tmr, bits, errs, errs_fin;
  logic             go, last, tmr_clr, tmr_en;
  logic             meas_clr, bits_en, errs_en;
  res_t             rec;

  assign go   = start && (st == S_IDLE || st == S_DONE);
  assign last = (m_out == m_hi) && (ss_out == ss_hi);

  // Timer restarts on every state change; only APPLY/SETTLE use it.
  assign tmr_clr  = (nxt != st);
  assign tmr_en   = (st == S_APPLY) || (st == S_SETTLE);
  assign meas_clr = (st != S_MEASURE);
  assign bits_en  = (st == S_MEASURE) && chk_val;
  assign errs_en  = bits_en && chk_err;

  assign errs_fin = (chk_err && errs != '1) ? errs + 1'b1 : errs;

  sat_cnt #(.W(CNT_W)) u_tmr (
    .clk (clk_h),
    .rst (rst),
    .clr (tmr_clr),
    .en  (tmr_en),
    .q   (tmr)
  );

  sat_cnt #(.W(CNT_W)) u_bits (
    .clk (clk_h),
    .rst (rst),
    .clr (meas_clr),
    .en  (bits_en),
    .q   (bits)
  );

  sat_cnt #(.W(CNT_W)) u_errs (
    .clk (clk_h),
    .rst (rst),
    .clr (meas_clr),
    .en  (errs_en),
    .q   (errs)
  );

  always_comb begin
    adv_ss = ss_out;
    adv_m  = m_out + 1'b1;
    if (m_out == m_hi) begin
      adv_m  = m_lo;
      adv_ss = ss_out + 1'b1;
    end
  end

  always_comb begin
    nxt = st;
    if (abort) begin
      nxt = S_IDLE;
    end else begin
      unique case (st)
        S_IDLE, S_DONE: if (start) nxt = S_APPLY;
        S_APPLY:        if (tmr == RST_LAST) nxt = S_SETTLE;
        S_SETTLE: begin
          if (chk_lock) nxt = S_MEASURE;
          else if (tmr == TO_LAST) nxt = S_REPORT;
        end
        S_MEASURE: begin
          if (chk_val && bits == nb - 1'b1) nxt = S_REPORT;
        end
        S_REPORT:       if (res_ready) nxt = S_NEXT;
        S_NEXT:         nxt = last ? S_DONE : S_APPLY;
        default:        nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_h) begin
    if (rst) begin
      st        <= S_IDLE;
      ss_out    <= '0;
      m_out     <= '0;
      phy_rst_n <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      res_valid <= 1'b0;
      rec       <= '0;
      ss_lo     <= '0;
      ss_hi     <= '0;
      m_lo      <= '0;
      m_hi      <= '0;
      nb        <= '0;
    end else begin
      st        <= nxt;
      phy_rst_n <= !(nxt == S_IDLE || nxt == S_APPLY);
      busy      <= !(nxt == S_IDLE || nxt == S_DONE);
      done      <= (nxt == S_DONE);
      if (nxt == S_IDLE) begin
        ss_out    <= '0;
        m_out     <= '0;
        res_valid <= 1'b0;
        rec       <= '0;
      end else begin
        if (go) begin
          ss_lo  <= ss_first;
          ss_hi  <= (ss_first > ss_last) ? ss_first : ss_last;
          m_lo   <= m_first;
          m_hi   <= (m_first > m_last) ? m_first : m_last;
          nb     <= (n_bits == '0) ? CNT_W'(1) : n_bits;
          ss_out <= ss_first;
          m_out  <= m_first;
        end else if (st == S_NEXT && nxt == S_APPLY) begin
          ss_out <= adv_ss;
          m_out  <= adv_m;
        end
        // Snapshot the record once on REPORT entry; it stays frozen.
        if (nxt == S_REPORT && st != S_REPORT) begin
          res_valid  <= 1'b1;
          rec.ss     <= ss_out;
          rec.m      <= m_out;
          rec.nolock <= (st == S_SETTLE);
          rec.bits   <= (st == S_SETTLE) ? '0 : RES_W'(nb);
          rec.errs   <= (st == S_SETTLE) ? '0 : RES_W'(errs_fin);
        end else if (nxt != S_REPORT) begin
          res_valid <= 1'b0;
        end
      end
    end
  end

  assign res_ss     = rec.ss;
  assign res_m      = rec.m;
  assign res_bits   = rec.bits[CNT_W-1:0];
  assign res_errs   = rec.errs[CNT_W-1:0];
  assign res_nolock = rec.nolock;

endmodule

// File: tb/tb_ber_sweep_ctrl.sv
// Bench for ber_sweep_ctrl: PRBS checker model plus a record scoreboard.
// Expected records are queued at sweep start and popped on handshakes.
module tb_ber_sweep_ctrl;

  logic        clk_h = 1'b0;
  logic        rst, start, abort;
  logic [3:0]  ss_first, ss_last;
  logic [2:0]  m_first, m_last;
  logic [23:0] n_bits;
  logic        chk_val, chk_err, chk_lock;
  logic [3:0]  ss_out;
  logic [2:0]  m_out;
  logic        phy_rst_n, busy, done, res_valid, res_ready;
  logic [3:0]  res_ss;
  logic [2:0]  res_m;
  logic [23:0] res_bits, res_errs;
  logic        res_nolock;

  ber_sweep_ctrl #(.CNT_W(24), .RST_CYC(16), .LOCK_TO(50)) dut (
    .clk_h      (clk_h),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .ss_first   (ss_first),
    .ss_last    (ss_last),
    .m_first    (m_first),
    .m_last     (m_last),
    .n_bits     (n_bits),
    .chk_val    (chk_val),
    .chk_err    (chk_err),
    .chk_lock   (chk_lock),
    .ss_out     (ss_out),
    .m_out      (m_out),
    .phy_rst_n  (phy_rst_n),
    .busy       (busy),
    .done       (done),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_ss     (res_ss),
    .res_m      (res_m),
    .res_bits   (res_bits),
    .res_errs   (res_errs),
    .res_nolock (res_nolock)
  );

  always #5 clk_h = ~clk_h;

  typedef struct {
    int ss;
    int m;
    int bits;
    int errs;
    int nolock;
  } rec_t;

  rec_t sbq[$];
  int   nchk = 0;
  int   nerr = 0;
  bit   err_mode = 1'b0;
  bit   lock_mode = 1'b1;
  int   cyc = 0;
  bit   gen_prev = 1'b0;
  int   vcnt = 0;
  bit   mon_phy = 1'b0;
  bit   mon_valid = 1'b0;
  int   lowcnt = 0;
  int   settle_cyc = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    nchk++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_h);
    #1;
  endtask

  // PRBS checker model: strobes only once the PHY has been out of reset
  // for a full cycle, error on every 10th counted strobe when enabled.
  initial begin
    chk_val  = 1'b0;
    chk_err  = 1'b0;
    chk_lock = 1'b1;
    forever begin
      @(posedge clk_h);
      #1;
      chk_lock = lock_mode;
      if (phy_rst_n && gen_prev) begin
        chk_val = ($urandom_range(0, 3) != 0);
        chk_err = chk_val && err_mode && (vcnt % 10 == 9);
        if (chk_val) vcnt++;
      end else begin
        chk_val = 1'b0;
        chk_err = 1'b0;
        if (!phy_rst_n) vcnt = 0;
      end
      gen_prev = phy_rst_n;
    end
  end

  // Output monitor: scoreboard pops, PHY reset length, timeout latency.
  initial begin
    forever begin
      @(negedge clk_h);
      cyc++;
      if (res_valid && res_ready && !abort && !rst) begin
        if (sbq.size() == 0) begin
          chk("sb_extra", sbq.size(), 1);
        end else begin
          rec_t e;
          e = sbq.pop_front();
          chk("rec_ss", res_ss, e.ss);
          chk("rec_m", res_m, e.m);
          chk("rec_bits", res_bits, e.bits);
          chk("rec_errs", res_errs, e.errs);
          chk("rec_nolock", res_nolock, e.nolock);
        end
      end
      if (busy && !phy_rst_n) begin
        lowcnt++;
      end else begin
        if (lowcnt != 0) chk("rst_len", lowcnt, 16);
        lowcnt = 0;
      end
      if (busy && phy_rst_n && !mon_phy) settle_cyc = cyc;
      if (res_valid && !mon_valid && res_nolock)
        chk("to_lat", cyc - settle_cyc, 50);
      mon_phy   = phy_rst_n;
      mon_valid = res_valid;
    end
  end

  task automatic run(input int sf, input int sl, input int mf,
                     input int ml, input int nb, input bit push);
    int sh, mh;
    ss_first = 4'(sf);
    ss_last  = 4'(sl);
    m_first  = 3'(mf);
    m_last   = 3'(ml);
    n_bits   = 24'(nb);
    start    = 1'b1;
    tick();
    start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_phy", phy_rst_n, 0);
    chk("start_ss", ss_out, sf);
    chk("start_m", m_out, mf);
    if (push) begin
      sh = (sf > sl) ? sf : sl;
      mh = (mf > ml) ? mf : ml;
      for (int s = sf; s <= sh; s++) begin
        for (int m = mf; m <= mh; m++) begin
          rec_t r;
          int eb;
          eb = (nb == 0) ? 1 : nb;
          r.ss     = s;
          r.m      = m;
          r.bits   = lock_mode ? eb : 0;
          r.errs   = (lock_mode && err_mode) ? eb / 10 : 0;
          r.nolock = lock_mode ? 0 : 1;
          sbq.push_back(r);
        end
      end
    end
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!done && n < budget) begin
      tick();
      n++;
    end
    chk("done", done, 1);
    chk("done_busy", busy, 0);
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    while (!res_valid && n < budget) begin
      tick();
      n++;
    end
    chk("valid_wait", res_valid, 1);
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    abort     = 1'b0;
    res_ready = 1'b1;
    ss_first  = '0;
    ss_last   = '0;
    m_first   = '0;
    m_last    = '0;
    n_bits    = '0;
    repeat (3) tick();
    chk("rst_ss", ss_out, 0);
    chk("rst_m", m_out, 0);
    chk("rst_phy", phy_rst_n, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", res_valid, 0);
    chk("rst_bits", res_bits, 0);
    chk("rst_errs", res_errs, 0);
    rst = 1'b0;
    tick();

    run(5, 5, 2, 2, 1000, 1);
    wait_done(3000);
    chk("sb_single", sbq.size(), 0);

    run(1, 2, 0, 1, 20, 1);
    wait_done(1000);
    chk("sb_grid", sbq.size(), 0);

    run(3, 1, 4, 4, 0, 1);
    wait_done(300);
    chk("sb_rev", sbq.size(), 0);

    err_mode = 1'b1;
    run(0, 0, 0, 0, 100, 1);
    wait_done(600);
    err_mode = 1'b0;
    chk("sb_err", sbq.size(), 0);

    lock_mode = 1'b0;
    run(7, 7, 1, 2, 10, 1);
    wait_done(600);
    lock_mode = 1'b1;
    chk("sb_to", sbq.size(), 0);

    res_ready = 1'b0;
    run(4, 4, 3, 3, 50, 1);
    wait_valid(500);
    repeat (20) begin
      tick();
      chk("bp_valid", res_valid, 1);
      chk("bp_ss", res_ss, 4);
      chk("bp_m", res_m, 3);
      chk("bp_bits", res_bits, 50);
      chk("bp_errs", res_errs, 0);
    end
    res_ready = 1'b1;
    wait_done(50);
    chk("sb_bp", sbq.size(), 0);

    res_ready = 1'b0;
    run(6, 6, 5, 6, 30, 0);
    wait_valid(500);
    abort     = 1'b1;
    res_ready = 1'b1;
    tick();
    abort = 1'b0;
    chk("ab_valid", res_valid, 0);
    chk("ab_busy", busy, 0);
    chk("ab_done", done, 0);
    chk("ab_ss", ss_out, 0);
    chk("ab_phy", phy_rst_n, 0);
    chk("ab_bits", res_bits, 0);
    repeat (50) tick();
    chk("ab_idle", busy, 0);

    run(2, 3, 0, 0, 500, 0);
    begin
      int n = 0;
      while (!phy_rst_n && n < 100) begin
        tick();
        n++;
      end
    end
    chk("mr_phy_up", phy_rst_n, 1);
    repeat (20) tick();
    chk("mr_busy_pre", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mr_ss", ss_out, 0);
    chk("mr_m", m_out, 0);
    chk("mr_phy", phy_rst_n, 0);
    chk("mr_busy", busy, 0);
    chk("mr_done", done, 0);
    chk("mr_valid", res_valid, 0);
    chk("mr_bits", res_bits, 0);
    repeat (800) tick();
    chk("mr_quiet", busy, 0);
    chk("mr_novalid", res_valid, 0);

    chk("sb_end", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
